// File: rtl/hss_pkg.sv
// Shared types for the wavelet frame controller.
// State encoding, clear length and sample width.
package hss_pkg;

  localparam int SAMPLE_W     = 16;
  localparam int CLEAR_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/env_fifo.sv
// Envelope output FIFO, first-word fall-through.
// Push and pop in the same cycle are legal even when full.
module env_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign count = cnt_q;
  assign rdata = mem_q[rd_ptr_q];

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Pointer and occupancy update; clear empties the FIFO.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/wavelet_frame_ctrl.sv
// Frame sequencer for the DB wavelet envelope datapath.
// Clears, feeds, flushes and drains one frame.
module wavelet_frame_ctrl
  import hss_pkg::*;
#(
  parameter int FRAME_LEN  = 1024,
  parameter int FLUSH_LEN  = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FRAME_LEN + FLUSH_LEN + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic                abort,
  input  logic                in_valid,
  input  logic [15:0]         in_data,
  output logic                in_ready,
  output logic                wv_rst_n,
  output logic                wv_ce,
  output logic [15:0]         wv_data,
  input  logic [15:0]         wv_out,
  input  logic                wv_we,
  output logic                out_valid,
  output logic [15:0]         out_data,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    out_count
);

  localparam int FAW = $clog2(FIFO_DEPTH);

  state_e             state_q, state_d;
  logic [1:0]         clr_cnt_q, clr_cnt_d;
  logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [15:0]        wv_data_q, wv_data_d;
  logic [15:0]        step_data;
  logic               fifo_clr;
  logic               fifo_push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FAW:0]       fifo_cnt;

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = ~fifo_empty;
  assign out_count = out_cnt_q;

  // Next state, handshakes and counters.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    in_cnt_d    = in_cnt_q;
    flush_cnt_d = flush_cnt_q;
    out_cnt_d   = out_cnt_q;
    fifo_clr    = 1'b0;
    in_ready    = 1'b0;
    wv_ce       = 1'b0;
    wv_rst_n    = 1'b0;
    done        = 1'b0;
    step_data   = wv_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d     = ST_CLEAR;
          clr_cnt_d   = '0;
          in_cnt_d    = '0;
          flush_cnt_d = '0;
          out_cnt_d   = '0;
          fifo_clr    = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == 2'(CLEAR_CYCLES - 1)) state_d = ST_FEED;
        else clr_cnt_d = clr_cnt_q + 2'd1;
      end
      ST_FEED: begin
        wv_rst_n  = 1'b1;
        in_ready  = ~fifo_full & ~abort;
        wv_ce     = in_valid & in_ready;
        step_data = in_data;
        if (wv_ce) begin
          in_cnt_d = in_cnt_q + CNT_W'(1);
          if (in_cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        wv_rst_n  = 1'b1;
        wv_ce     = ~fifo_full & ~abort;
        step_data = '0;
        if (wv_ce) begin
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
          if (flush_cnt_q == CNT_W'(FLUSH_LEN - 1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        wv_rst_n = 1'b1;
        if (fifo_cnt == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        wv_rst_n = 1'b1;
        done     = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    fifo_push = wv_ce & wv_we;
    if (fifo_push) out_cnt_d = out_cnt_q + CNT_W'(1);

    if (abort && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      fifo_clr = 1'b1;
      done     = 1'b0;
    end

    wv_data   = wv_ce ? step_data : wv_data_q;
    wv_data_d = wv_data;
  end

  // Controller state registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      in_cnt_q    <= '0;
      flush_cnt_q <= '0;
      out_cnt_q   <= '0;
      wv_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      in_cnt_q    <= in_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      out_cnt_q   <= out_cnt_d;
      wv_data_q   <= wv_data_d;
    end
  end

  env_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .wdata (wv_out),
    .pop   (out_ready),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule

// File: tb/tb_wavelet_frame_ctrl.sv
// Bench for wavelet_frame_ctrl: frame table plus corner sequences.
// Envelope words are tracked through a queue.
module tb_wavelet_frame_ctrl;

  localparam int FL = 16;
  localparam int FZ = 4;
  localparam int FD = 8;
  localparam int CW = $clog2(FL + FZ + 1);

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [15:0]   in_data;
  logic          in_ready;
  logic          wv_rst_n;
  logic          wv_ce;
  logic [15:0]   wv_data;
  logic [15:0]   wv_out;
  logic          wv_we;
  logic          out_valid;
  logic [15:0]   out_data;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          done;
  logic [CW-1:0] out_count;

  int checks = 0;
  int failures = 0;

  int we_per = 8;
  int model_step = 0;
  int data_idx = 0;
  int ce_cnt = 0;
  int zero_cnt = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int words_out = 0;
  int clr_cnt = 0;
  logic [15:0] sb[$];

  assign in_data = 16'h0100 + data_idx[15:0];
  assign wv_we   = (model_step % we_per) == (we_per - 1);
  assign wv_out  = 16'h5000 + model_step[15:0];

  wavelet_frame_ctrl #(
    .FRAME_LEN  (FL),
    .FLUSH_LEN  (FZ),
    .FIFO_DEPTH (FD)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wv_rst_n  (wv_rst_n),
    .wv_ce     (wv_ce),
    .wv_data   (wv_data),
    .wv_out    (wv_out),
    .wv_we     (wv_we),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .out_count (out_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic reset_mon();
    ce_cnt = 0;
    zero_cnt = 0;
    hs_cnt = 0;
    done_cnt = 0;
    words_out = 0;
    clr_cnt = 0;
    model_step = 0;
    data_idx = 0;
    sb.delete();
  endtask

  // Datapath model advances one step per consumed sample.
  always @(posedge CLK) begin
    #1;
    model_step = ce_cnt;
    data_idx = hs_cnt;
  end

  // Monitor sampled mid-cycle, before the capturing edge.
  always @(negedge CLK) begin
    if (RST) begin
      if (busy && !wv_rst_n) clr_cnt++;
      if (in_valid && in_ready) hs_cnt++;
      if (done) done_cnt++;
      if (wv_ce) begin
        if (ce_cnt < FL) begin
          chk("feed_data", int'(wv_data), int'(16'h0100 + ce_cnt[15:0]));
        end else if (wv_data == 16'h0) begin
          zero_cnt++;
        end
        if (wv_we) sb.push_back(wv_out);
        ce_cnt++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          chk("out_word", int'(out_data), int'(sb.pop_front()));
        end
        words_out++;
      end
    end
  end

  typedef struct {
    int per;
    bit gap;
    bit smid;
    int exp_words;
  } vec_t;

  vec_t tbl[3];

  task automatic run_frame(input int per, input bit gap, input bit smid);
    reset_mon();
    we_per = per;
    out_ready = 1'b1;
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      in_valid = gap ? ~in_valid : 1'b1;
      start = (smid && i == 6);
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("frame_done_seen", int'(done_cnt != 0), 1);
    tick();
    tick();
  endtask

  initial begin
    logic [15:0] held;
    tbl[0] = '{per: 8, gap: 1'b0, smid: 1'b1, exp_words: 2};
    tbl[1] = '{per: 4, gap: 1'b1, smid: 1'b0, exp_words: 5};
    tbl[2] = '{per: 3, gap: 1'b0, smid: 1'b0, exp_words: 6};

    repeat (3) tick();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_wv_ce", int'(wv_ce), 0);
    chk("rst_wv_rst_n", int'(wv_rst_n), 0);
    chk("rst_wv_data", int'(wv_data), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out_count", int'(out_count), 0);
    RST = 1'b1;
    tick();

    for (int t = 0; t < 3; t++) begin
      run_frame(tbl[t].per, tbl[t].gap, tbl[t].smid);
      chk($sformatf("v%0d_clear_len", t), clr_cnt, 2);
      chk($sformatf("v%0d_ce", t), ce_cnt, FL + FZ);
      chk($sformatf("v%0d_zero_ce", t), zero_cnt, FZ);
      chk($sformatf("v%0d_handshakes", t), hs_cnt, FL);
      chk($sformatf("v%0d_out_count", t), int'(out_count), tbl[t].exp_words);
      chk($sformatf("v%0d_words", t), words_out, tbl[t].exp_words);
      chk($sformatf("v%0d_done_cnt", t), done_cnt, 1);
      chk($sformatf("v%0d_busy", t), int'(busy), 0);
      chk($sformatf("v%0d_sb_left", t), sb.size(), 0);
    end

    // Backpressure: consumer stalled, every step produces a word.
    reset_mon();
    we_per = 1;
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && ce_cnt < FD; i++) tick();
    chk("bp_pushes", ce_cnt, FD);
    chk("bp_in_ready", int'(in_ready), 0);
    chk("bp_wv_ce", int'(wv_ce), 0);
    chk("bp_out_valid", int'(out_valid), 1);
    chk("bp_out_count", int'(out_count), FD);
    held = out_data;
    repeat (3) tick();
    chk("bp_head_stable", int'(out_data), int'(held));
    chk("bp_still_stalled", ce_cnt, FD);
    out_ready = 1'b1;
    for (int i = 0; i < 400 && done_cnt == 0; i++) tick();
    in_valid = 1'b0;
    chk("bp_done_seen", int'(done_cnt != 0), 1);
    tick();
    chk("bp_words", words_out, FL + FZ);
    chk("bp_out_count_end", int'(out_count), FL + FZ);
    chk("bp_sb_left", sb.size(), 0);

    // Abort at flush_cnt == 2 with words still queued.
    reset_mon();
    we_per = 4;
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && ce_cnt < FL + 2; i++) tick();
    chk("ab_reach_flush2", ce_cnt, FL + 2);
    chk("ab_pre_out_valid", int'(out_valid), 1);
    abort = 1'b1;
    #1;
    chk("ab_ce_same_cycle", int'(wv_ce), 0);
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("ab_busy", int'(busy), 0);
    chk("ab_out_valid", int'(out_valid), 0);
    chk("ab_wv_rst_n", int'(wv_rst_n), 0);
    repeat (6) tick();
    chk("ab_no_done", done_cnt, 0);
    chk("ab_no_more_ce", ce_cnt, FL + 2);
    out_ready = 1'b1;

    // start and abort together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", int'(busy), 0);
    chk("sa_wv_rst_n", int'(wv_rst_n), 0);
    tick();
    chk("sa_busy2", int'(busy), 0);

    // Reset mid-frame clears out_count too.
    reset_mon();
    we_per = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    repeat (8) tick();
    chk("mr_count_nonzero", int'(out_count != 0), 1);
    RST = 1'b0;
    #1;
    chk("mr_busy", int'(busy), 0);
    chk("mr_out_count", int'(out_count), 0);
    chk("mr_out_valid", int'(out_valid), 0);
    chk("mr_wv_ce", int'(wv_ce), 0);
    in_valid = 1'b0;
    tick();
    RST = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
